// File: rtl/inst_fetch_queue_if.sv
// Bus bundle for inst_fetch_queue: byte-read port towards RAM and decoded-instruction port towards the decoder.
// Handshakes: a byte moves when mem_req & mem_ack; a queue entry moves when dq_valid & dq_ready.
interface inst_fetch_queue_if #(
  parameter int ADDR_W = 16,
  parameter int WIDTH  = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              dq_valid;
  logic              dq_ready;
  logic [15:0]       dq_inst;
  logic [ADDR_W-1:0] dq_pc;
  logic [1:0]        dq_bytes;
  logic [WIDTH-1:0]  dq_rhs;

  modport master (
    output mem_req, mem_addr, dq_valid, dq_inst, dq_pc, dq_bytes, dq_rhs,
    input  mem_ack, mem_rdata, dq_ready
  );

  modport slave (
    input  mem_req, mem_addr, dq_valid, dq_inst, dq_pc, dq_bytes, dq_rhs,
    output mem_ack, mem_rdata, dq_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Byte-serial instruction fetch with a QDEPTH-entry pre-decoded instruction FIFO and redirect flush.
// Optional bus-timeout fault (FAULT state, sticky fetch_fault) is built only when IFQ_TIMEOUT_EN is defined.
module inst_fetch_queue #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 16,
  parameter int QDEPTH  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  inst_fetch_queue_if.master bus,
  output logic              fetch_fault,
  output logic [1:0]        dbg_state
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  if (QDEPTH < 2 || QDEPTH > 8 || (QDEPTH & (QDEPTH - 1)) != 0 || WIDTH < 12 || TIMEOUT < 1)
  begin : g_param_err
    $error("inst_fetch_queue: unsupported parameter set");
  end

`ifdef IFQ_TIMEOUT_EN
  typedef enum logic [1:0] {F_OP = 2'd0, F_ARG = 2'd1, FAULT = 2'd2} state_t;
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [TCW-1:0] TO_MAX = TCW'(TIMEOUT);
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           fault_q, fault_d;
`else
  typedef enum logic [1:0] {F_OP = 2'd0, F_ARG = 2'd1} state_t;
`endif

  typedef struct packed {
    logic [15:0]       inst;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        bytes;
    logic [WIDTH-1:0]  rhs;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] op_pc_q, op_pc_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  entry_t            ent_q [QDEPTH];
  entry_t            ent_d [QDEPTH];
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic   xfer, pop, push, has_head;
  entry_t new_ent, head;

  // Operand pre-decode for 2-byte instructions.
  function automatic logic [WIDTH-1:0] calc_rhs(input logic [15:0] inst);
    logic [WIDTH-1:0] r;
    if (inst[15:11] == 5'b11000 || inst[15:11] == 5'b11010)
      r = {{(WIDTH-11){inst[10]}}, inst[10:0]};
    else if (inst[10:8] == 3'b001)
      r = WIDTH'({inst[7:0], 8'h00});
    else
      r = WIDTH'(inst[7:0]);
    return r;
  endfunction

  assign has_head = (count_q != '0);
  assign head     = ent_q[rd_q];
  assign xfer     = mem_req_q & bus.mem_ack;
  assign pop      = has_head & bus.dq_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    op_pc_d    = op_pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    ent_d      = ent_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    new_ent    = '0;
`ifdef IFQ_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    fault_d    = fault_q;
`endif
    if (redirect) begin
      // Flush wins over any ack or pop landing in the same cycle.
      state_d = F_OP;
      pc_d    = redirect_pc;
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
`ifdef IFQ_TIMEOUT_EN
      to_cnt_d = '0;
      fault_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        F_OP: begin
          if (xfer) begin
            op_d    = bus.mem_rdata;
            op_pc_d = pc_q;
            pc_d    = pc_q + ADDR_W'(1);
            if (bus.mem_rdata[7]) begin
              state_d = F_ARG;
            end else begin
              push          = 1'b1;
              new_ent.inst  = {bus.mem_rdata, 8'h00};
              new_ent.pc    = pc_q;
              new_ent.bytes = 2'd1;
              new_ent.rhs   = '0;
            end
          end
        end
        F_ARG: begin
          if (xfer) begin
            push          = 1'b1;
            new_ent.inst  = {op_q, bus.mem_rdata};
            new_ent.pc    = op_pc_q;
            new_ent.bytes = 2'd2;
            new_ent.rhs   = calc_rhs({op_q, bus.mem_rdata});
            pc_d          = pc_q + ADDR_W'(1);
            state_d       = F_OP;
          end
        end
        default: ;
      endcase
`ifdef IFQ_TIMEOUT_EN
      if (state_q != FAULT) begin
        if (xfer) begin
          to_cnt_d = '0;
        end else if (mem_req_q) begin
          to_cnt_d = to_cnt_q + TCW'(1);
          if (to_cnt_d == TO_MAX) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end
      end
`endif
      if (push) begin
        ent_d[wr_q] = new_ent;
        wr_d        = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    // The opcode fetch reserves the slot, so the arg fetch never waits for space.
    case (state_d)
      F_OP:    mem_req_d = (count_d < CW'(QDEPTH));
      F_ARG:   mem_req_d = 1'b1;
      default: mem_req_d = 1'b0;
    endcase
    mem_addr_d = pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= F_OP;
      pc_q       <= '0;
      op_q       <= '0;
      op_pc_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      for (int i = 0; i < QDEPTH; i++) ent_q[i] <= '0;
`ifdef IFQ_TIMEOUT_EN
      to_cnt_q   <= '0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      op_pc_q    <= op_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      for (int i = 0; i < QDEPTH; i++) ent_q[i] <= ent_d[i];
`ifdef IFQ_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      fault_q    <= fault_d;
`endif
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.dq_valid = has_head;
  assign bus.dq_inst  = has_head ? head.inst  : '0;
  assign bus.dq_pc    = has_head ? head.pc    : '0;
  assign bus.dq_bytes = has_head ? head.bytes : '0;
  assign bus.dq_rhs   = has_head ? head.rhs   : '0;
  assign dbg_state    = state_q;

`ifdef IFQ_TIMEOUT_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule
